// File: rtl/gray_sum_accumulator.sv
// Gray-sum accumulator: sums 5-bit Gray samples into a saturating
// binary total and returns the result Gray-coded over valid/ready.
module gray_sum_accumulator #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       gs,
    input  logic             gcout,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_gray,
    output logic             acc_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0] acc_bin;
    logic [4:0]       count;
    logic [4:0]       target;

    logic [4:0]       samp_g;
    logic [4:0]       samp_b;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat_bin;
    logic             sat;
    logic             accept;
    logic [4:0]       count_inc;

    // Gray-to-binary of the 5-bit sample, MSB first
    always_comb begin
        samp_g    = {gcout, gs};
        samp_b    = '0;
        samp_b[4] = samp_g[4];
        for (int i = 3; i >= 0; i--) begin
            samp_b[i] = samp_b[i+1] ^ samp_g[i];
        end
    end

    // Saturating add of the zero-extended sample
    always_comb begin
        sum     = {1'b0, acc_bin} + {{(ACC_W-4){1'b0}}, samp_b};
        sat     = sum[ACC_W];
        sat_bin = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    assign accept    = in_valid & in_ready;
    assign count_inc = count + 5'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept && count_inc == target) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state == ACCUM);
        acc_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: run setup on start, accumulate on accept, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_bin  <= '0;
            acc_gray <= '0;
            acc_ovf  <= 1'b0;
            count    <= '0;
            target   <= '0;
        end else if (state == IDLE && start) begin
            acc_bin  <= '0;
            acc_gray <= '0;
            acc_ovf  <= 1'b0;
            count    <= '0;
            target   <= (num_samples == 4'd0) ? 5'd16 : {1'b0, num_samples};
        end else if (state == ACCUM && accept) begin
            acc_bin  <= sat_bin;
            acc_gray <= sat_bin ^ (sat_bin >> 1);
            acc_ovf  <= acc_ovf | sat;
            count    <= count_inc;
        end
    end

endmodule

// File: tb/tb_gray_sum_accumulator.sv
// Directed bench for gray_sum_accumulator with hand-computed
// expected values; one checking task counts every comparison.
module tb_gray_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_samples;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] gs;
    logic       gcout;
    logic       acc_valid;
    logic       out_ready;
    logic [7:0] acc_gray;
    logic       acc_ovf;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    gray_sum_accumulator #(.ACC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gs          (gs),
        .gcout       (gcout),
        .acc_valid   (acc_valid),
        .out_ready   (out_ready),
        .acc_gray    (acc_gray),
        .acc_ovf     (acc_ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic set_samp(input logic [4:0] g);
        {gcout, gs} = g;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = 4'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        {gcout, gs} = 5'b0;
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_gray",  acc_gray, 0);
        check("rst_ovf",   acc_ovf, 0);
        check("rst_busy",  busy, 0);
        rst = 1'b0;
        tick();

        // Basic run: 3 x binary 5
        do_start(4'd3);
        set_samp(5'b00111);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("basic_rdy", in_ready, 1);
            check("basic_nvld", acc_valid, 0);
            tick();
            if (i == 0) check("basic_g5", acc_gray, 8'h07);
        end
        in_valid = 1'b0;
        check("basic_rdy_lo", in_ready, 0);
        check("basic_vld", acc_valid, 1);
        check("basic_gray", acc_gray, 8'h08);
        check("basic_ovf", acc_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_idle_vld", acc_valid, 0);
        check("basic_idle_busy", busy, 0);
        check("basic_idle_gray", acc_gray, 8'h08);

        // Backpressure on both sides
        do_start(4'd3);
        set_samp(5'b00111);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick();
        check("bp_stall1", acc_gray, 8'h07);
        check("bp_rdy1", in_ready, 1);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick();
        check("bp_stall2", acc_gray, 8'h0F);
        check("bp_rdy2", in_ready, 1);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_vld", acc_valid, 1);
            check("bp_hold_gray", acc_gray, 8'h08);
            tick();
        end
        check("bp_hold_vld4", acc_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", busy, 0);

        // Saturation: 9 x binary 30
        do_start(4'd9);
        set_samp(5'b10001);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("sat_240", acc_gray, 8'h88);
        check("sat_noovf", acc_ovf, 0);
        tick();
        in_valid = 1'b0;
        check("sat_vld", acc_valid, 1);
        check("sat_gray", acc_gray, 8'h80);
        check("sat_ovf", acc_ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sat_ovf_idle", acc_ovf, 1);

        // Zero means 16; this start also clears acc_ovf
        do_start(4'd0);
        check("z_ovf_clr", acc_ovf, 0);
        check("z_gray_clr", acc_gray, 0);
        set_samp(5'b00001);
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("z_15_vld", acc_valid, 0);
        check("z_15_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("z_16_vld", acc_valid, 1);
        check("z_16_gray", acc_gray, 8'h18);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Ignored start in ACCUM and DONE
        do_start(4'd3);
        set_samp(5'b00111);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        do_start(4'd1);
        check("ign_acc_busy", in_ready, 1);
        check("ign_acc_gray", acc_gray, 8'h07);
        in_valid = 1'b1; tick();
        check("ign_acc_tgt", acc_valid, 0);
        tick(); in_valid = 1'b0;
        check("ign_done_vld", acc_valid, 1);
        check("ign_done_gray", acc_gray, 8'h08);
        start = 1'b1; num_samples = 4'd1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("ign_idle_busy", busy, 0);
        check("ign_idle_gray", acc_gray, 8'h08);
        do_start(4'd2);
        check("ign_new_rdy", in_ready, 1);
        check("ign_new_gray", acc_gray, 0);
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        check("ign_new_vld", acc_valid, 1);
        check("ign_new_sum", acc_gray, 8'h0F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Async reset mid-run
        do_start(4'd3);
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        check("ar_pre_gray", acc_gray, 8'h0F);
        #2 rst = 1'b1;
        #1;
        check("ar_rdy", in_ready, 0);
        check("ar_busy", busy, 0);
        check("ar_gray", acc_gray, 0);
        check("ar_vld", acc_valid, 0);
        check("ar_ovf", acc_ovf, 0);
        #2 rst = 1'b0;
        tick();
        do_start(4'd3);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("ar_run_vld", acc_valid, 1);
        check("ar_run_gray", acc_gray, 8'h08);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ar_run_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
